// File: rtl/gpu_mem_pkg.sv
// Shared constants and types for the GPU memory subsystem.
// Holds the SRAM map, draw-engine client indices and the arbiter state type.
package gpu_mem_pkg;

  localparam int unsigned LAYER1_BASE = 0;
  localparam int unsigned LAYER2_BASE = 65536;
  localparam int unsigned TEX1_BASE   = 131072;
  localparam int unsigned TEX2_BASE   = 135168;
  localparam int unsigned TEX3_BASE   = 139264;
  localparam int unsigned OUT_BASE    = 143360;

  localparam int unsigned CLIENT_FILL = 0;
  localparam int unsigned CLIENT_LINE = 1;
  localparam int unsigned CLIENT_OUT  = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HANDOFF
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_owner_i, wrapping.
module rr_picker #(
  parameter int unsigned NumClients = 3,
  parameter int unsigned IdxW       = (NumClients > 1) ? $clog2(NumClients) : 1
) (
  input  logic [NumClients-1:0] req_i,
  input  logic [IdxW-1:0]       last_owner_i,
  output logic [IdxW-1:0]       winner_o,
  output logic                  valid_o
);

  int unsigned       idx;
  logic [IdxW-1:0]   sel;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int unsigned k = 1; k <= NumClients; k++) begin
      idx = (32'(last_owner_i) + k) % NumClients;
      sel = IdxW'(idx);
      if (!valid_o && req_i[sel]) begin
        valid_o  = 1'b1;
        winner_o = sel;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter for the draw engines: round-robin, exclusive grant per
// transaction, one HANDOFF cycle between owners, sticky protocol error flag.
module sram_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_SIZE_BITS  = 24,
  parameter int unsigned WORD_SIZE_BYTES = 3,
  parameter int unsigned DATA_SIZE_WORDS = 64,
  parameter int unsigned NUM_CLIENTS     = 3,
  localparam int unsigned DW     = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8,
  localparam int unsigned OwnerW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CLIENTS-1:0]         req,
  output logic [NUM_CLIENTS-1:0]         gnt,
  input  logic [NUM_CLIENTS-1:0]         c_read_enable,
  input  logic [NUM_CLIENTS-1:0]         c_write_enable,
  input  logic [NUM_CLIENTS*ADDR_SIZE_BITS-1:0] c_address,
  input  logic [NUM_CLIENTS*DW-1:0]      c_write_data,
  output logic [DW-1:0]                  c_read_data,
  output logic                           read_enable,
  output logic                           write_enable,
  output logic [ADDR_SIZE_BITS-1:0]      address,
  output logic [DW-1:0]                  write_data,
  input  logic [DW-1:0]                  read_data,
  output logic                           busy,
  output logic                           protocol_err
);

  arb_state_t                state_q, state_d;
  logic [OwnerW-1:0]         owner_q, owner_d;
  logic [OwnerW-1:0]         last_owner_q, last_owner_d;
  logic [NUM_CLIENTS-1:0]    gnt_q, gnt_d;
  logic                      perr_q, perr_d;
  logic [DW-1:0]             wdata_q, wdata_d;

  logic [OwnerW-1:0]         pick_winner;
  logic                      pick_valid;
  logic                      in_grant;
  logic                      own_re, own_we;
  logic [ADDR_SIZE_BITS-1:0] own_addr;
  logic [DW-1:0]             own_wdata;

  logic [ADDR_SIZE_BITS-1:0] addr_arr  [NUM_CLIENTS];
  logic [DW-1:0]             wdata_arr [NUM_CLIENTS];

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign addr_arr[i]  = c_address[i*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
    assign wdata_arr[i] = c_write_data[i*DW +: DW];
  end

  rr_picker #(
    .NumClients (NUM_CLIENTS),
    .IdxW       (OwnerW)
  ) u_picker (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .winner_o     (pick_winner),
    .valid_o      (pick_valid)
  );

  assign in_grant  = (state_q == GRANT);
  assign own_re    = c_read_enable[owner_q];
  assign own_we    = c_write_enable[owner_q];
  assign own_addr  = addr_arr[owner_q];
  assign own_wdata = wdata_arr[owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d             = pick_winner;
          gnt_d               = '0;
          gnt_d[pick_winner]  = 1'b1;
          state_d             = GRANT;
        end
      end
      GRANT: begin
        // Remember the owner's data so the wide bus stays quiet outside GRANT.
        wdata_d = own_wdata;
        if (!req[owner_q]) begin
          gnt_d        = '0;
          last_owner_d = owner_q;
          state_d      = HANDOFF;
        end
      end
      HANDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // gnt_q is all-zero outside GRANT, so every client counts as a non-owner there.
  always_comb begin
    perr_d = perr_q
           | (|((c_read_enable | c_write_enable) & ~gnt_q))
           | (in_grant & own_re & own_we);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OwnerW'(NUM_CLIENTS - 1);
      gnt_q        <= '0;
      perr_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      perr_q       <= perr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign gnt          = gnt_q;
  assign busy         = (state_q != IDLE);
  assign protocol_err = perr_q;
  assign read_enable  = in_grant & own_re;
  assign write_enable = in_grant & own_we & ~own_re;
  assign address      = in_grant ? own_addr : '0;
  assign write_data   = in_grant ? own_wdata : wdata_q;
  assign c_read_data  = read_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level reference model of owner / handoff / error rules.
module tb_sram_arbiter;

  localparam int unsigned AW = 24;
  localparam int unsigned NC = 3;
  localparam int unsigned DW = 3 * 64 * 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [NC-1:0]     req, gnt, c_re, c_we;
  logic [NC*AW-1:0]  c_address;
  logic [NC*DW-1:0]  c_write_data;
  logic [DW-1:0]     c_read_data, write_data, read_data;
  logic              read_enable, write_enable, busy, protocol_err;
  logic [AW-1:0]     address;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: who owns the port, how long until the next contest, error flag.
  int            m_owner;
  int            m_cool;
  int            m_last;
  bit            m_err;
  logic [DW-1:0] m_wdata;

  always #5 clk = ~clk;

  sram_arbiter u_dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .req            (req),
    .gnt            (gnt),
    .c_read_enable  (c_re),
    .c_write_enable (c_we),
    .c_address      (c_address),
    .c_write_data   (c_write_data),
    .c_read_data    (c_read_data),
    .read_enable    (read_enable),
    .write_enable   (write_enable),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .busy           (busy),
    .protocol_err   (protocol_err)
  );

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] addr_of(int c);
    return c_address[c*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata_of(int c);
    return c_write_data[c*DW +: DW];
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cool  = 0;
    m_last  = NC - 1;
    m_err   = 1'b0;
    m_wdata = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < NC; c++)
      if ((c_re[c] || c_we[c]) && c != m_owner) m_err = 1'b1;
    if (m_owner >= 0 && c_re[m_owner] && c_we[m_owner]) m_err = 1'b1;
    if (m_owner >= 0) begin
      m_wdata = wdata_of(m_owner);
      if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req != '0) begin
      for (int k = 1; k <= NC; k++) begin
        int c;
        c = (m_last + k) % NC;
        if (req[c]) begin
          m_owner = c;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NC-1:0] e_gnt;
    logic          e_re, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    e_gnt  = '0;
    e_re   = 1'b0;
    e_we   = 1'b0;
    e_addr = '0;
    e_wd   = m_wdata;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_re   = c_re[m_owner];
      e_we   = c_we[m_owner] && !c_re[m_owner];
      e_addr = addr_of(m_owner);
      e_wd   = wdata_of(m_owner);
    end
    chk({tag, "/gnt"}, 128'(gnt), 128'(e_gnt));
    chk({tag, "/busy"}, 128'(busy), 128'(m_owner >= 0 || m_cool > 0));
    chk({tag, "/perr"}, 128'(protocol_err), 128'(m_err));
    chk({tag, "/re"}, 128'(read_enable), 128'(e_re));
    chk({tag, "/we"}, 128'(write_enable), 128'(e_we));
    chk({tag, "/addr"}, 128'(address), 128'(e_addr));
    tests++;
    assert (write_data === e_wd) else begin
      fails++;
      $error("FAIL %s/wdata: observed[95:0] %0h expected[95:0] %0h",
             tag, write_data[95:0], e_wd[95:0]);
    end
    tests++;
    assert (c_read_data === read_data) else begin
      fails++;
      $error("FAIL %s/rdata: observed[95:0] %0h expected[95:0] %0h",
             tag, c_read_data[95:0], read_data[95:0]);
    end
  endtask

  task automatic apply_reset();
    #2;
    n_rst = 1'b0;
    req   = '0;
    c_re  = '0;
    c_we  = '0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    int ord [4];
    int o;
    int waited;
    logic [DW-1:0] wd;

    n_rst        = 1'b0;
    req          = '0;
    c_re         = '0;
    c_we         = '0;
    c_address    = '0;
    c_write_data = '0;
    read_data    = rand_word();
    model_reset();

    // 1: reset values, first grant, client 0 read at 65536
    apply_reset();
    chk("t1/rst_gnt", 128'(gnt), 128'(0));
    chk("t1/rst_busy", 128'(busy), 128'(0));
    req = 3'b001;
    tick();
    chk("t1/gnt", 128'(gnt), 128'(3'b001));
    c_re[0] = 1'b1;
    c_address[0*AW +: AW] = 24'd65536;
    #1;
    chk("t1/addr", 128'(address), 128'(24'd65536));
    chk("t1/re", 128'(read_enable), 128'(1));
    check_all("t1/grant");
    req = '0;
    tick();
    c_re = '0;
    #1;
    check_all("t1/handoff");
    tick();
    check_all("t1/idle");

    // 2: all three request from reset, each holds 4 cycles; order 0,1,2,0
    apply_reset();
    ord = '{0, 1, 2, 0};
    req = 3'b111;
    tick();
    for (int g = 0; g < 4; g++) begin
      o = ord[g];
      chk($sformatf("t2/gnt%0d", g), 128'(gnt), 128'(1) << o);
      for (int h = 0; h < 4; h++) begin
        c_re = '0;
        c_re[o] = 1'b1;
        c_address[o*AW +: AW] = AW'($urandom);
        if (h == 3) req[o] = 1'b0;
        #1;
        check_all($sformatf("t2/own%0d", g));
        tick();
      end
      c_re = '0;
      if (g == 0) req[0] = 1'b1;
      #1;
      chk($sformatf("t2/ho_gnt%0d", g), 128'(gnt), 128'(0));
      chk($sformatf("t2/ho_re%0d", g), 128'(read_enable), 128'(0));
      chk($sformatf("t2/ho_we%0d", g), 128'(write_enable), 128'(0));
      chk($sformatf("t2/ho_busy%0d", g), 128'(busy), 128'(1));
      check_all("t2/handoff");
      tick();
      chk($sformatf("t2/idle_gnt%0d", g), 128'(gnt), 128'(0));
      check_all("t2/idle");
      if (g < 3) tick();
    end

    // 3: non-owner write is blocked and flagged stickily
    apply_reset();
    req = 3'b010;
    tick();
    chk("t3/gnt", 128'(gnt), 128'(3'b010));
    c_re[1] = 1'b1;
    c_address[1*AW +: AW] = 24'd4096;
    c_we[2] = 1'b1;
    c_address[2*AW +: AW] = 24'd143360;
    #1;
    chk("t3/we", 128'(write_enable), 128'(0));
    chk("t3/addr", 128'(address), 128'(24'd4096));
    chk("t3/perr_pre", 128'(protocol_err), 128'(0));
    tick();
    chk("t3/perr", 128'(protocol_err), 128'(1));
    c_we = '0;
    tick();
    chk("t3/perr_sticky", 128'(protocol_err), 128'(1));
    check_all("t3/after");

    // 4: final write in the same cycle as the release, then two dead cycles
    apply_reset();
    req = 3'b001;
    tick();
    wd = rand_word();
    c_we[0] = 1'b1;
    c_address[0*AW +: AW] = 24'd256;
    c_write_data[0*DW +: DW] = wd;
    req[0] = 1'b0;
    #1;
    chk("t4/we", 128'(write_enable), 128'(1));
    chk("t4/addr", 128'(address), 128'(24'd256));
    check_all("t4/last");
    tick();
    c_we = '0;
    req  = 3'b110;
    #1;
    chk("t4/ho_gnt", 128'(gnt), 128'(0));
    tests++;
    assert (write_data === wd) else begin
      fails++;
      $error("FAIL t4/wd_hold: observed[95:0] %0h expected[95:0] %0h",
             write_data[95:0], wd[95:0]);
    end
    check_all("t4/handoff");
    tick();
    chk("t4/idle_gnt", 128'(gnt), 128'(0));
    tick();
    chk("t4/next_gnt", 128'(gnt), 128'(3'b010));
    check_all("t4/next");

    // 5: asynchronous reset mid-read, then client 1 wins first
    apply_reset();
    req = 3'b001;
    tick();
    c_re[0] = 1'b1;
    c_address[0*AW +: AW] = 24'd1234;
    #1;
    check_all("t5/read");
    #2;
    n_rst = 1'b0;
    #1;
    chk("t5/gnt", 128'(gnt), 128'(0));
    chk("t5/re", 128'(read_enable), 128'(0));
    chk("t5/addr", 128'(address), 128'(0));
    chk("t5/busy", 128'(busy), 128'(0));
    model_reset();
    c_re = '0;
    req  = 3'b110;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    chk("t5/first", 128'(gnt), 128'(3'b010));
    check_all("t5/after");
    req = '0;
    tick();
    tick();
    tick();

    // 6: lone client 2 with a 1-cycle gap is re-granted 3 edges after release
    apply_reset();
    req = 3'b100;
    tick();
    chk("t6/gnt0", 128'(gnt), 128'(3'b100));
    for (int r = 0; r < 3; r++) begin
      tick();
      req = '0;
      tick();
      req = 3'b100;
      waited = 1;
      while (gnt == '0 && waited < 6) begin
        check_all("t6/gap");
        tick();
        waited++;
      end
      chk($sformatf("t6/spacing%0d", r), 128'(waited), 128'(3));
      chk($sformatf("t6/regnt%0d", r), 128'(gnt), 128'(3'b100));
    end

    // Random traffic against the model
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NC; c++)
        if (!req[c] && $urandom_range(0, 2) == 0) req[c] = 1'b1;
      c_re = '0;
      c_we = '0;
      for (int c = 0; c < NC; c++) c_address[c*AW +: AW] = AW'($urandom);
      if (m_owner >= 0) begin
        o = m_owner;
        case ($urandom_range(0, 3))
          0: c_re[o] = 1'b1;
          1: c_we[o] = 1'b1;
          default: ;
        endcase
        c_write_data[o*DW +: DW] = rand_word();
        if ($urandom_range(0, 3) == 0) req[o] = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) read_data = rand_word();
      #1;
      check_all("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM arbiter shared by the draw engines (fill, line rasterizer, output compositor). Each engine raises a request, receives an exclusive grant for its whole read-modify-write sequence, and drives the SRAM through this block. Grants are round-robin so no engine starves. It sits between the engines and the SRAM controller, replacing their direct connections to `read_enable`, `write_enable`, `address` and `write_data`.

## Interface
- `ADDR_SIZE_BITS`, 24: SRAM word address width.
- `WORD_SIZE_BYTES`, 3: bytes per pixel word.
- `DATA_SIZE_WORDS`, 64: words per SRAM beat. DW = WORD_SIZE_BYTES*DATA_SIZE_WORDS*8, which is 1536 by default.
- `NUM_CLIENTS`, 3: number of requesters. Client 0 = fill, 1 = line, 2 = output compositor.

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req`  in  NUM_CLIENTS  per-client request. Held high for the whole transaction.
- `gnt`  out  NUM_CLIENTS  one-hot grant. Registered.
- `c_read_enable`  in  NUM_CLIENTS  per-client read strobe.
- `c_write_enable`  in  NUM_CLIENTS  per-client write strobe.
- `c_address`  in  NUM_CLIENTS*ADDR_SIZE_BITS  per-client address. Client n occupies slice [n*ADDR_SIZE_BITS +: ADDR_SIZE_BITS].
- `c_write_data`  in  NUM_CLIENTS*DW  per-client write data. Client n occupies slice [n*DW +: DW].
- `c_read_data`  out  DW  `read_data` broadcast to all clients, unregistered.
- `read_enable`, `write_enable`  out  1  to SRAM.
- `address`  out  ADDR_SIZE_BITS  to SRAM.
- `write_data`  out  DW  to SRAM.
- `read_data`  in  DW  from SRAM.
- `busy`  out  1  high whenever state is not IDLE.
- `protocol_err`  out  1  sticky. Cleared only by reset.

## Operation
The state machine has three states: IDLE, GRANT, HANDOFF.

- **IDLE**
  - If any `req` bit is set, pick the winner with the round-robin picker, starting the search at `last_owner+1` modulo NUM_CLIENTS.
  - Register `owner`, set `gnt[owner]`, go to GRANT.
  - With no request, stay in IDLE.
- **GRANT**
  - SRAM outputs are a combinational mux of the owner's `c_read_enable`, `c_write_enable`, `c_address` and `c_write_data`.
  - When `req[owner]` is sampled low, clear `gnt`, set `last_owner = owner`, go to HANDOFF.
- **HANDOFF**
  - Lasts exactly one cycle.
  - SRAM enables forced to 0, `address` = 0.
  - Returns to IDLE.
  - Requests present during HANDOFF are arbitrated in the following IDLE cycle.

Outputs outside GRANT:
- `read_enable` = 0, `write_enable` = 0, `address` = 0.
- `write_data` holds the last muxed value. Do not toggle 1536 bits needlessly.

Rules:
- No preemption. An owner keeps the port regardless of other requests.
- Enables from non-owners are ignored and never reach the SRAM.
- `protocol_err` sets in the cycle after any of these:
  - a non-owner asserts `c_read_enable` or `c_write_enable`;
  - the owner asserts both enables in the same cycle. In that case the SRAM sees the read only; write is suppressed.
- `owner` and `last_owner` are $clog2(NUM_CLIENTS) bits wide. Wrap from NUM_CLIENTS-1 to 0.

## Timing
- Reset values:
  - state IDLE, `gnt` = 0, `busy` = 0, `protocol_err` = 0, `read_enable` = 0, `write_enable` = 0, `address` = 0, `write_data` = 0.
  - `last_owner` = NUM_CLIENTS-1, so client 0 wins the first contest.
- Request latency: `req` high at edge t in IDLE gives `gnt` high after edge t+1. The client drives the SRAM from cycle t+1.
- Release: `req` low sampled at edge t drops `gnt` after t+1. The earliest next grant is after t+3 (HANDOFF, then IDLE arbitration).
- A client may drop `req` in the same cycle as its final strobe. That strobe still reaches the SRAM.
- A client that drops `req` and re-raises it in the HANDOFF cycle loses to any other pending requester. If it is the only requester, it is re-granted.
- `n_rst` asserted mid-transaction:
  - all outputs go to reset values immediately;
  - the grant is lost;
  - clients must restart.

## Structure
- Shared package `gpu_mem_pkg` holds:
  - the SRAM map constants: LAYER1_BASE 0, LAYER2_BASE 65536, TEX1_BASE 131072, TEX2_BASE 135168, TEX3_BASE 139264, OUT_BASE 143360;
  - client indices CLIENT_FILL = 0, CLIENT_LINE = 1, CLIENT_OUT = 2;
  - the `arb_state_t` enum {IDLE, GRANT, HANDOFF}.
- Sub-module `rr_picker` is purely combinational.
  - Inputs: `req` vector and `last_owner`.
  - Outputs: winner index and a `valid` flag.
- The rest is roughly 200 lines of RTL.

## Test plan
1. Reset with `req` = 3'b000 → all outputs 0, `busy` = 0. Then `req` = 3'b001 → `gnt` = 3'b001 one cycle later. Client 0 with `c_address` = 65536 and a read → `address` = 65536, `read_enable` = 1.
2. `req` = 3'b111 simultaneously from reset, each client holding for 4 cycles → grant order 0, 1, 2, 0. There is exactly one HANDOFF cycle between grants, with `read_enable` and `write_enable` at 0 in it.
3. Client 1 owns the port. Client 2 asserts `c_write_enable` with `c_address` = 143360 → `write_enable` stays 0, and `protocol_err` = 1 on the next cycle and remains set.
4. Client 0 drops `req` in the same cycle as `c_write_enable` = 1, `c_address` = 256 → the SRAM sees the write at 256, `gnt` clears on the next edge, and no other client is granted for 2 cycles.
5. Client 0 owns the port mid-read. `n_rst` is pulsed low → `gnt`, `read_enable` and `address` drop to 0 asynchronously. After reset, `req` = 3'b110 → client 1 is granted first.
6. Only client 2 requests, repeatedly, with a 1-cycle gap → it is re-granted each time, with grant-to-grant spacing of 3 cycles after release.
